// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  arb_pkg
//  Shared state encoding and width helper for the find-first-one arbiter.
//  Revision: 1.0
// ============================================================================
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int ffo_idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ffo_n.sv
`default_nettype none
// ============================================================================
//  ffo_n
//  Combinational find-first-one: lowest index (leftmost bit) wins.
//  Revision: 1.0
// ============================================================================
module ffo_n
    import arb_pkg::*;
#(
    parameter  int N   = 32,
    localparam int IDW = ffo_idw(N)
) (
    input  logic [0:N-1]   b,
    output logic           v,
    output logic [0:IDW-1] p
);

    // Scanning from the top down lets the lowest set index overwrite the rest.
    always_comb begin
        v = 1'b0;
        p = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (b[i]) begin
                v = 1'b1;
                p = IDW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ffo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  ffo_rr_arbiter
//  Round-robin arbiter with rotating pointer, hold-until-release ownership
//  and optional hold-limit revocation.
//  Revision: 1.0
// ============================================================================
module ffo_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 32,
    parameter  int MAX_HOLD = 0,
    localparam int IDW      = ffo_idw(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic [0:N-1]   req,
    output logic [0:N-1]   grant,
    output logic           grant_valid,
    output logic [0:IDW-1] grant_id,
    output logic           timeout
);

    localparam int HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [0:N-1]   grant_q, grant_d;
    logic           grant_valid_q, grant_valid_d;
    logic [0:IDW-1] grant_id_q, grant_id_d;
    logic           timeout_q, timeout_d;

    logic [0:N-1]   masked;
    logic           m_v, r_v;
    logic [0:IDW-1] m_p, r_p;
    logic [IDW-1:0] win_id;
    logic           limit_hit;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] & (IDW'(i) >= ptr_q);
        end
    end

    ffo_n #(.N(N)) u_ffo_masked (.b(masked), .v(m_v), .p(m_p));
    ffo_n #(.N(N)) u_ffo_req    (.b(req),    .v(r_v), .p(r_p));

    // Fall back to the unmasked search once nothing sits at or above ptr.
    assign win_id    = m_v ? m_p : r_p;
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && r_v) begin
                    state_d         = BUSY;
                    owner_d         = win_id;
                    grant_d         = '0;
                    grant_d[win_id] = 1'b1;
                    grant_valid_d   = 1'b1;
                    grant_id_d      = win_id;
                    hold_cnt_d      = HCW'(1);
                end
            end
            BUSY: begin
                if (!req[owner_q] || limit_hit) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    ptr_d         = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
                    // Still requesting here means the limit forced the release.
                    timeout_d     = req[owner_q];
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ffo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_ffo_rr_arbiter
//  Directed self-checking bench for ffo_rr_arbiter and ffo_n.
//  Revision: 1.0
// ============================================================================
module tb_ffo_rr_arbiter;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable, enable_h;
    logic [0:N-1] req, req_h, b;
    logic [0:N-1] grant, grant_h;
    logic         grant_valid, grant_valid_h, timeout, timeout_h, v;
    logic [0:4]   grant_id, grant_id_h, p;

    int checks = 0;
    int errors = 0;

    wire [38:0] obs   = {grant, grant_valid, grant_id, timeout};
    wire [38:0] obs_h = {grant_h, grant_valid_h, grant_id_h, timeout_h};

    always #5 clock = ~clock;

    ffo_rr_arbiter #(.N(N), .MAX_HOLD(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
    );

    ffo_rr_arbiter #(.N(N), .MAX_HOLD(4)) dut_h (
        .clock(clock), .reset(reset), .enable(enable_h), .req(req_h),
        .grant(grant_h), .grant_valid(grant_valid_h), .grant_id(grant_id_h), .timeout(timeout_h)
    );

    ffo_n #(.N(N)) u_ffo (.b(b), .v(v), .p(p));

    // Expected {grant, grant_valid, grant_id, timeout}
    function automatic logic [38:0] expo(input logic vld, input int id, input logic to);
        logic [0:N-1] g;
        g = '0;
        if (vld) g[id] = 1'b1;
        return {g, vld, vld ? 5'(id) : 5'd0, to};
    endfunction

    function automatic logic [0:N-1] bits2(input int a, input int c);
        logic [0:N-1] r;
        r = '0;
        r[a] = 1'b1;
        r[c] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; enable_h = 1'b1; req = '0; req_h = '0; b = '0;
        #2;
        checks++;
        if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL reset_outputs got %h expected %h", obs, expo(1'b0, 0, 1'b0)); end
        checks++;
        if (obs_h !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL reset_outputs_h got %h expected %h", obs_h, expo(1'b0, 0, 1'b0)); end
        #10 reset = 1'b0;
    endtask

    task automatic test_basic();
        req = '0; req[5] = 1'b1;
        step();
        checks++;
        if (obs !== expo(1'b1, 5, 1'b0)) begin errors++; $display("FAIL basic_grant5 got %h expected %h", obs, expo(1'b1, 5, 1'b0)); end
        req = '0;
        step();
        checks++;
        if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL basic_release5 got %h expected %h", obs, expo(1'b0, 0, 1'b0)); end
    endtask

    task automatic test_ptr();
        req = bits2(2, 9);
        step();
        checks++;
        if (obs !== expo(1'b1, 9, 1'b0)) begin errors++; $display("FAIL ptr6_picks9 got %h expected %h", obs, expo(1'b1, 9, 1'b0)); end
        req = '0; req[2] = 1'b1;
        step();
        checks++;
        if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL ptr_dead_cycle got %h expected %h", obs, expo(1'b0, 0, 1'b0)); end
        step();
        checks++;
        if (obs !== expo(1'b1, 2, 1'b0)) begin errors++; $display("FAIL ptr_wrap_to2 got %h expected %h", obs, expo(1'b1, 2, 1'b0)); end
        req = '0;
        step();
        req = bits2(2, 4);
        step();
        checks++;
        if (obs !== expo(1'b1, 4, 1'b0)) begin errors++; $display("FAIL ptr3_picks4 got %h expected %h", obs, expo(1'b1, 4, 1'b0)); end
        req = '0;
        step();
        checks++;
        if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL ptr_release4 got %h expected %h", obs, expo(1'b0, 0, 1'b0)); end
    endtask

    task automatic test_rotation();
        reset = 1'b1;
        #2 reset = 1'b0;
        req = '1;
        step();
        for (int k = 0; k <= N; k++) begin
            checks++;
            if (obs !== expo(1'b1, k % N, 1'b0)) begin errors++; $display("FAIL rotate_grant k=%0d got %h expected %h", k, obs, expo(1'b1, k % N, 1'b0)); end
            req = '1; req[k % N] = 1'b0;
            step();
            checks++;
            if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL rotate_idle k=%0d got %h expected %h", k, obs, expo(1'b0, 0, 1'b0)); end
            if (k < N) begin
                req = '1;
                step();
            end
        end
        req = '0;
    endtask

    task automatic test_async_reset();
        req = '0; req[10] = 1'b1;
        step();
        checks++;
        if (obs !== expo(1'b1, 10, 1'b0)) begin errors++; $display("FAIL async_pre_grant got %h expected %h", obs, expo(1'b1, 10, 1'b0)); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL async_clear got %h expected %h", obs, expo(1'b0, 0, 1'b0)); end
        #2 reset = 1'b0;
        req = bits2(0, 31);
        step();
        checks++;
        if (obs !== expo(1'b1, 0, 1'b0)) begin errors++; $display("FAIL async_ptr0 got %h expected %h", obs, expo(1'b1, 0, 1'b0)); end
        req = '0;
        step();
    endtask

    task automatic test_enable();
        enable = 1'b0; req = '0; req[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL enable_low_idle i=%0d got %h expected %h", i, obs, expo(1'b0, 0, 1'b0)); end
        end
        enable = 1'b1;
        step();
        checks++;
        if (obs !== expo(1'b1, 3, 1'b0)) begin errors++; $display("FAIL enable_grant3 got %h expected %h", obs, expo(1'b1, 3, 1'b0)); end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== expo(1'b1, 3, 1'b0)) begin errors++; $display("FAIL enable_low_busy i=%0d got %h expected %h", i, obs, expo(1'b1, 3, 1'b0)); end
        end
        req = '0;
        step();
        enable = 1'b1;
        step();
        checks++;
        if (obs !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL zero_req_idle got %h expected %h", obs, expo(1'b0, 0, 1'b0)); end
    endtask

    task automatic test_hold_limit();
        req_h = '0; req_h[7] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_h !== expo(1'b1, 7, 1'b0)) begin errors++; $display("FAIL hold_first i=%0d got %h expected %h", i, obs_h, expo(1'b1, 7, 1'b0)); end
        end
        step();
        checks++;
        if (obs_h !== expo(1'b0, 0, 1'b1)) begin errors++; $display("FAIL hold_timeout1 got %h expected %h", obs_h, expo(1'b0, 0, 1'b1)); end
        step();
        checks++;
        if (obs_h !== expo(1'b1, 7, 1'b0)) begin errors++; $display("FAIL hold_regrant7 got %h expected %h", obs_h, expo(1'b1, 7, 1'b0)); end
        req_h = bits2(7, 8);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_h !== expo(1'b1, 7, 1'b0)) begin errors++; $display("FAIL hold_second i=%0d got %h expected %h", i, obs_h, expo(1'b1, 7, 1'b0)); end
        end
        step();
        checks++;
        if (obs_h !== expo(1'b0, 0, 1'b1)) begin errors++; $display("FAIL hold_timeout2 got %h expected %h", obs_h, expo(1'b0, 0, 1'b1)); end
        step();
        checks++;
        if (obs_h !== expo(1'b1, 8, 1'b0)) begin errors++; $display("FAIL hold_next8 got %h expected %h", obs_h, expo(1'b1, 8, 1'b0)); end
        req_h = '0;
        step();
        checks++;
        if (obs_h !== expo(1'b0, 0, 1'b0)) begin errors++; $display("FAIL hold_release_no_timeout got %h expected %h", obs_h, expo(1'b0, 0, 1'b0)); end
    endtask

    task automatic test_ffo();
        for (int i = 0; i < N; i++) begin
            b = '0; b[i] = 1'b1;
            #1;
            checks++;
            if (v !== 1'b1 || p !== 5'(i)) begin errors++; $display("FAIL ffo_onehot i=%0d got v=%b p=%0d expected v=1 p=%0d", i, v, p, i); end
            for (int j = 0; j < N; j++) b[j] = (j >= i);
            #1;
            checks++;
            if (v !== 1'b1 || p !== 5'(i)) begin errors++; $display("FAIL ffo_tail i=%0d got v=%b p=%0d expected v=1 p=%0d", i, v, p, i); end
        end
        b = '0;
        #1;
        checks++;
        if (v !== 1'b0 || p !== 5'd0) begin errors++; $display("FAIL ffo_zero got v=%b p=%0d expected v=0 p=0", v, p); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ptr();
        test_rotation();
        test_async_reset();
        test_enable();
        test_hold_limit();
        test_ffo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ffo_rr_arbiter.md
# ffo_rr_arbiter

Round-robin arbiter that shares one resource among N requesters, using a parameterised find-first-one priority encoder to pick the next owner. A rotating priority pointer gives fair service, and a grant stays with its owner until that owner releases it. An optional hold limit revokes a grant that is held too long. The block sits in front of any shared datapath resource and drives its select/enable from `grant_id` and `grant_valid`.

## Interface
- `N`, 32: number of requesters; 2..32.
- `MAX_HOLD`, 0: maximum consecutive grant cycles before revocation; 0 disables the limit.
- `IDW`, $clog2(N): width of `grant_id`; derived, not overridden.

- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `enable`  in  1: when low, no new grant is issued; an existing grant is unaffected.
- `req`  in  [0:N-1]: level requests; bit 0 is the leftmost bit and the lowest index.
- `grant`  out  [0:N-1]: one-hot registered grant; all zero when there is no owner.
- `grant_valid`  out  1: high while some requester owns the resource.
- `grant_id`  out  [0:IDW-1]: index of the owner; 0 when `grant_valid` is low.
- `timeout`  out  1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- FSM states are IDLE and BUSY. Registers are `state`, `ptr` (IDW bits), `owner`, `hold_cnt` and the outputs.
- Selection (combinational, IDLE only):
  - `masked = req & {bits at index >= ptr}`.
  - If `masked` is nonzero, the winner is the first one of `masked`. Otherwise the winner is the first one of `req`.
  - "First one" means the lowest index, i.e. the leftmost bit.
- IDLE → BUSY: requires `enable` high and `req` nonzero. On that edge:
  - `grant[winner]` is set.
  - `grant_id` = winner, `grant_valid` = 1.
  - `hold_cnt` = 1.
- BUSY, `req[owner]` still high, limit not reached: hold the grant and increment `hold_cnt`. The counter saturates; it must not wrap.
- BUSY → IDLE on release (`req[owner]` low):
  - Clear `grant`, `grant_valid` and `grant_id`.
  - `ptr` = (owner+1) mod N.
- BUSY → IDLE on revocation (`MAX_HOLD` ≠ 0, `hold_cnt` == `MAX_HOLD`, `req[owner]` still high):
  - Same updates as a release, plus `timeout` = 1 for one cycle.
- Other requesters' `req` bits never affect a grant in BUSY.
- A `req` bit going high while that requester is the owner has no effect.

## Timing
- Reset values: `state` = IDLE, `ptr` = 0, `grant` = 0, `grant_valid` = 0, `grant_id` = 0, `timeout` = 0, `hold_cnt` = 0.
- Reset is asynchronous on assertion and may arrive mid-grant. Outputs clear immediately and `ptr` returns to 0.
- Grant latency: a request sampled at edge k is granted on outputs after edge k (visible in cycle k+1).
- Release latency: `req[owner]` low at edge m drops the grant after edge m.
- Dead cycle: IDLE always lasts at least one cycle between grants, so the next grant appears after edge m+1. Back-to-back ownership therefore has a one-cycle gap.
- With `MAX_HOLD` = H, the owner sees exactly H cycles of `grant`. `timeout` is coincident with the first cycle `grant` is low.
- `ptr` wrap: owner N-1 sets `ptr` = 0.
- `enable` low in IDLE holds the FSM in IDLE. `ptr` is unchanged.
- `req` all zero in IDLE keeps the outputs at zero. There is no X propagation from the encoder position; `grant_id` is forced to 0.

## Structure
- Package `arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, BUSY};
  - a `ffo_idw(N)` width helper.
- Sub-module `ffo_n` #(N): combinational find-first-one. Inputs `b[0:N-1]`; outputs `v` and `p[0:IDW-1]`, leftmost = index 0.
  - Instantiated twice, once on `masked` and once on `req`.
  - Tested standalone against exhaustive one-hot-with-leading-zeros patterns.
- The arbiter is a single always_ff block plus combinational mask/select. Target size is about 150–250 lines.

## Test plan
- Reset then `req` = bit 5 only → `grant_id` = 5 after 1 edge. Drop `req[5]` → grant low next cycle and `ptr` = 6.
- `ptr` = 6, `req` = bits {2,9} → 9 wins. Release → `req` {2} wins after the dead cycle, and `ptr` becomes 3.
- All 32 requests held, each owner releases after 1 cycle → grants rotate 0,1,…,31,0 with one idle cycle between each. This checks fairness and wrap.
- `MAX_HOLD` = 4, `req[7]` stuck high → exactly 4 grant cycles, a `timeout` pulse, one idle cycle, then regrant to 7. Repeat with `req` {7,8} → 8 is granted next.
- Assert `reset` asynchronously mid-BUSY (between edges) → all outputs 0 immediately. After release, `req` {0,31} → 0 is granted (`ptr` is 0).
- `enable` = 0 with `req` = bit 3 for 5 cycles → no grant. Raise `enable` → grant 3 after 1 edge. Lower `enable` while BUSY → the grant persists.
